// File: rtl/seg7_capture.sv
// seg7_capture: watches a multiplexed active-low 7-segment bus and rebuilds
// the hex value shown on every digit. A (digit, pattern) pair has to stay
// put for STABLE_CYCLES registered samples before it is captured. This keeps
// ghost patterns seen during scan transitions out of the digit registers.
module seg7_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic                    clr_err,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    upd_valid,
  output logic [2:0]              upd_idx,
  output logic [3:0]              upd_value,
  output logic                    err_pattern,
  output logic                    err_sticky
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] SC  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

  // Inverse of the board's hex decoder. Returns {err, value}.
  function automatic logic [4:0] lookup(input logic [6:0] s);
    case (s)
      7'b1000000: lookup = 5'h00;
      7'b1111001: lookup = 5'h01;
      7'b0100100: lookup = 5'h02;
      7'b0110000: lookup = 5'h03;
      7'b0011001: lookup = 5'h04;
      7'b0010010: lookup = 5'h05;
      7'b0000010: lookup = 5'h06;
      7'b1111000: lookup = 5'h07;
      7'b0000000: lookup = 5'h08;
      7'b0011000: lookup = 5'h09;
      7'b1111111: lookup = 5'h0F;
      default:    lookup = 5'h1E;
    endcase
  endfunction

  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [6:0]            pat_q, pat_d;

  logic [NUM_DIGITS-1:0][3:0] digits_q;
  logic [NUM_DIGITS-1:0]      vld_q;
  logic                       upd_valid_q, err_pattern_q, err_sticky_q;
  logic [2:0]                 upd_idx_q;
  logic [3:0]                 upd_value_q;

  logic       qual, same, cap, wr, lk_err, cur_vld;
  logic [2:0] sidx;
  logic [3:0] nlow, lk_val, cur_val;

  // Input sample registers; every decision below uses these copies.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= 7'h7F;
      an_q  <= '1;
    end else begin
      seg_q <= seg_in;
      an_q  <= an_in;
    end
  end

  // Strobe qualification: exactly one anode low selects a digit.
  always_comb begin
    nlow = '0;
    sidx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) begin
        nlow = nlow + 4'd1;
        sidx = i[2:0];
      end
    end
    qual = (nlow == 4'd1);
  end

  // State and tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pat_q   <= 7'h7F;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
    end
  end

  // Next state: count how long the current pair has held, capture once at threshold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    cap     = 1'b0;
    same    = (idx_q == sidx) && (pat_q == seg_q);
    if (!qual) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q != IDLE && same) begin
      if (state_q == TRACK) begin
        if (cnt_q < SC) cnt_d = cnt_q + ONE;
        if (cnt_d == SC) begin
          cap     = 1'b1;
          state_d = HELD;
        end
      end
    end else begin
      state_d = TRACK;
      cnt_d   = ONE;
      idx_d   = sidx;
      pat_d   = seg_q;
      if (cnt_d == SC) begin
        cap     = 1'b1;
        state_d = HELD;
      end
    end
  end

  // Decode the captured pattern and decide whether it changes the stored digit.
  always_comb begin
    {lk_err, lk_val} = lookup(seg_q);
    cur_val = '0;
    cur_vld = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sidx == i[2:0]) begin
        cur_val = digits_q[i];
        cur_vld = vld_q[i];
      end
    end
    wr = cap && (!cur_vld || cur_val != lk_val);
  end

  // Digit registers, update pulse and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q      <= '0;
      vld_q         <= '0;
      upd_valid_q   <= 1'b0;
      upd_idx_q     <= '0;
      upd_value_q   <= '0;
      err_pattern_q <= 1'b0;
      err_sticky_q  <= 1'b0;
    end else begin
      upd_valid_q   <= wr;
      err_pattern_q <= wr && lk_err;
      if (wr) begin
        upd_idx_q   <= sidx;
        upd_value_q <= lk_val;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sidx == i[2:0]) begin
            digits_q[i] <= lk_val;
            vld_q[i]    <= 1'b1;
          end
        end
      end
      // A new error on the same cycle as clr_err leaves the flag set.
      if (wr && lk_err)  err_sticky_q <= 1'b1;
      else if (clr_err)  err_sticky_q <= 1'b0;
    end
  end

  assign digits_out  = digits_q;
  assign digit_valid = vld_q;
  assign upd_valid   = upd_valid_q;
  assign upd_idx     = upd_idx_q;
  assign upd_value   = upd_value_q;
  assign err_pattern = err_pattern_q;
  assign err_sticky  = err_sticky_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed stimulus pushes expected update pulses
// into a queue; a negedge monitor pops and compares each upd_valid pulse.
module tb_seg7_capture;
  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk = 0, rst = 1, clr_err = 0;
  logic [6:0]    seg_in = 7'h7F;
  logic [ND-1:0] an_in = '1;
  logic [4*ND-1:0] digits_out;
  logic [ND-1:0] digit_valid;
  logic          upd_valid, err_pattern, err_sticky;
  logic [2:0]    upd_idx;
  logic [3:0]    upd_value;

  seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in), .clr_err(clr_err),
    .digits_out(digits_out), .digit_valid(digit_valid), .upd_valid(upd_valid),
    .upd_idx(upd_idx), .upd_value(upd_value), .err_pattern(err_pattern),
    .err_sticky(err_sticky));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] idx;
    logic [3:0] val;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every update pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (upd_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_upd", {29'd0, upd_idx}, 32'hFFFF);
      end else begin
        e = q.pop_front();
        chk("upd_idx",     {29'd0, upd_idx},    {29'd0, e.idx});
        chk("upd_value",   {28'd0, upd_value},  {28'd0, e.val});
        chk("err_pattern", {31'd0, err_pattern}, {31'd0, e.err});
        if (e.cyc >= 0) chk("upd_cycle", cyc, e.cyc);
      end
    end else if (err_pattern) begin
      chk("err_without_upd", 32'd1, 32'd0);
    end
  end

  // Drive one digit/pattern right after a clock edge and hold it n cycles.
  task automatic hold(input logic [ND-1:0] an, input logic [6:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expect a capture for a pair driven now: first sampled next edge, captured SC edges later.
  task automatic expect_upd(input logic [2:0] idx, input logic [3:0] val, input logic err);
    exp_t e;
    e.idx = idx; e.val = val; e.err = err; e.cyc = cyc + 1 + SC;
    q.push_back(e);
  endtask

  logic [6:0] scan_pat [4] = '{7'b0110000, 7'b1111001, 7'b0011001, 7'b1111001};
  logic [3:0] scan_val [4] = '{4'd3, 4'd1, 4'd4, 4'd1};

  initial begin
    // 1: reset with a live qualified pattern on the bus
    an_in = 4'b1110; seg_in = 7'b0100100;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digits", {16'd0, digits_out}, 32'd0);
    chk("rst_valid",  {28'd0, digit_valid}, 32'd0);
    chk("rst_upd",    {31'd0, upd_valid}, 32'd0);
    chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
    an_in = '1; seg_in = 7'h7F;
    rst = 0;
    hold('1, 7'h7F, 2);

    // 2: digit 0 shows "2"
    expect_upd(3'd0, 4'd2, 1'b0);
    hold(4'b1110, 7'b0100100, 10);
    chk("t2_digit0", {28'd0, digits_out[3:0]}, 32'd2);
    chk("t2_valid",  {28'd0, digit_valid}, 32'b0001);
    hold('1, 7'h7F, 2);

    // 3: "4" for 3 cycles is dropped, "5" for 4 cycles is captured
    hold(4'b1101, 7'b0011001, 3);
    expect_upd(3'd1, 4'd5, 1'b0);
    hold(4'b1101, 7'b0010010, 4);
    hold('1, 7'h7F, 3);
    chk("t3_digit1", {28'd0, digits_out[7:4]}, 32'd5);

    // 4: scan 3,1,4,1 twice; second pass repeats nothing
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < 4; d++) begin
        logic [3:0] an;
        an = ~(4'b0001 << d);
        if (r == 0) expect_upd(d[2:0], scan_val[d], 1'b0);
        hold(an, scan_pat[d], 8);
      end
    end
    hold('1, 7'h7F, 3);
    chk("t4_digits", {16'd0, digits_out}, 32'h1413);
    chk("t4_valid",  {28'd0, digit_valid}, 32'b1111);

    // 5: two anodes low never qualifies
    hold(4'b1100, 7'b0000000, 20);
    hold('1, 7'h7F, 2);
    chk("t5_digits", {16'd0, digits_out}, 32'h1413);

    // 6: unknown pattern on digit 2, then clear the sticky flag
    expect_upd(3'd2, 4'hE, 1'b1);
    hold(4'b1011, 7'b1010101, 4);
    hold('1, 7'h7F, 3);
    chk("t6_sticky", {31'd0, err_sticky}, 32'd1);
    chk("t6_digit2", {28'd0, digits_out[11:8]}, 32'hE);
    clr_err = 1;
    @(posedge clk); #1;
    clr_err = 0;
    chk("t6_cleared", {31'd0, err_sticky}, 32'd0);

    // Blank pattern on digit 0 decodes to F
    expect_upd(3'd0, 4'hF, 1'b0);
    hold(4'b1110, 7'b1111111, 5);
    hold('1, 7'h7F, 2);
    chk("blank_digit0", {28'd0, digits_out[3:0]}, 32'hF);

    // Reset at count 3 on digit 3: no capture, everything cleared
    hold(4'b0111, 7'b1111000, 4);
    rst = 1; an_in = '1; seg_in = 7'h7F;
    @(posedge clk); #1;
    rst = 0;
    hold('1, 7'h7F, 8);
    chk("midrst_digits", {16'd0, digits_out}, 32'd0);
    chk("midrst_valid",  {28'd0, digit_valid}, 32'd0);
    chk("midrst_sticky", {31'd0, err_sticky}, 32'd0);

    chk("pending_expect", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
